// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst/response encodings, FSM state encodings and
// the WRAP-length legality helper used by the burst address generators.
// No ports; imported by axi_burst_addr_gen and axi_burst_ram.
package axi_pkg;

  // Burst type encodings (AxBURST)
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  // Response encodings (xRESP)
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Read FSM
  typedef logic [0:0] rd_state_t;
  localparam rd_state_t R_IDLE  = 1'b0;
  localparam rd_state_t R_BURST = 1'b1;

  // Write FSM
  typedef logic [1:0] wr_state_t;
  localparam wr_state_t W_IDLE = 2'd0;
  localparam wr_state_t W_DATA = 2'd1;
  localparam wr_state_t W_RESP = 2'd2;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Purpose : next-beat byte address for FIXED / INCR / WRAP AXI bursts.
// Latency : purely combinational, zero cycles.
// Backpr. : none; the caller decides when to register next_addr_o.
// Ports   : addr_i current beat address, size_i AxSIZE, len_i AxLEN,
//           burst_i AxBURST -> next_addr_o address of the following beat.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [7:0]        len_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_W'(1) << size_i;
    incr_addr = addr_i + step;
    // Wrap window is (len+1) beats of 2^size bytes; only the bits inside
    // the window advance, the upper bits stay pinned to the window base.
    wrap_mask = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
    next_addr_o = addr_i;
    case (burst_i)
      BURST_INCR: next_addr_o = incr_addr;
      BURST_WRAP: begin
        if (wrap_len_ok(len_i)) begin
          next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
        end else begin
          // Illegal wrap length degrades to an incrementing burst.
          next_addr_o = incr_addr;
        end
      end
      // FIXED and the reserved encoding both hold the address.
      default: next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_burst_ram.sv
// Purpose : AXI4 slave memory, FIXED/INCR/WRAP bursts up to 256 beats,
//           independent read and write channels over a dual-port array.
// Latency : first read beat one cycle after AR acceptance, then one beat per
//           cycle; write response the cycle after the final W beat.
// Backpr. : rdata/rid/rresp/rlast hold while rvalid && !rready; bvalid holds
//           until bready; AR/AW are not re-accepted until the burst finishes.
// Ports   : aclk/aresetn; AR (arid..arvalid/arready), R (rid..rvalid/rready),
//           AW (awid..awvalid/awready), W (wid..wvalid/wready), B (bid, bresp,
//           bvalid/bready). Lock/cache/prot and wid are accepted and ignored.
// Config  : define AXI_BURST_RAM_RANGE_CHECK_EN to return DECERR for beats
//           outside the array; otherwise the word index wraps modulo DEPTH.
module axi_burst_ram
  import axi_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 32,
  parameter int                ID_W      = 4,
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                aclk,
  input  logic                aresetn,
  // read address
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic [1:0]          arlock,
  input  logic [3:0]          arcache,
  input  logic [2:0]          arprot,
  input  logic                arvalid,
  output logic                arready,
  // read data
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  // write address
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic [1:0]          awlock,
  input  logic [3:0]          awcache,
  input  logic [2:0]          awprot,
  input  logic                awvalid,
  output logic                awready,
  // write data
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  // write response
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam int         OFFS     = $clog2(STRB_W);
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [2:0] SIZE_MAX = 3'(OFFS);

  logic [DATA_W-1:0] mem [DEPTH];

  // Word index of a byte address; upper bits are dropped, which gives the
  // modulo-DEPTH aliasing when range checking is not built in.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] rel;
    rel = (a - BASE_ADDR) >> OFFS;
    return rel[IDX_W-1:0];
  endfunction

`ifdef AXI_BURST_RAM_RANGE_CHECK_EN
  // Addresses below BASE_ADDR underflow to large values and are caught too.
  function automatic logic addr_oob(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] rel;
    rel = a - BASE_ADDR;
    return (rel >> (OFFS + IDX_W)) != '0;
  endfunction
`endif

  // ---------------------------------------------------------------- read --
  rd_state_t         rd_state_q, rd_state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [7:0]        rlen_q, rlen_d;
  logic [2:0]        rsize_q, rsize_d;
  logic [1:0]        rburst_q, rburst_d;
  logic              rslv_q, rslv_d;
  logic [7:0]        rcnt_q, rcnt_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  logic              ar_hs, r_hs, r_last;
  logic              rd_load;
  logic [ADDR_W-1:0] raddr_next;
  logic [ADDR_W-1:0] rd_look_addr;
  logic              rd_look_slv;
  logic              rd_look_dec;
  logic [1:0]        rd_look_resp;
  logic [IDX_W-1:0]  rd_look_idx;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr_gen (
    .addr_i      (raddr_q),
    .size_i      (rsize_q),
    .len_i       (rlen_q),
    .burst_i     (rburst_q),
    .next_addr_o (raddr_next)
  );

  assign ar_hs  = arvalid && (rd_state_q == R_IDLE);
  assign r_hs   = (rd_state_q == R_BURST) && rready;
  assign r_last = (rcnt_q == rlen_q);

  always_comb begin
    rd_state_d   = rd_state_q;
    rid_d        = rid_q;
    rlen_d       = rlen_q;
    rsize_d      = rsize_q;
    rburst_d     = rburst_q;
    rslv_d       = rslv_q;
    rcnt_d       = rcnt_q;
    raddr_d      = raddr_q;
    rd_load      = 1'b0;
    rd_look_addr = raddr_next;
    rd_look_slv  = rslv_q;
    if (ar_hs) begin
      rd_state_d   = R_BURST;
      rid_d        = arid;
      rlen_d       = arlen;
      rsize_d      = arsize;
      rburst_d     = arburst;
      rcnt_d       = 8'd0;
      raddr_d      = araddr;
      rd_load      = 1'b1;
      rd_look_addr = araddr;
      rd_look_slv  = (arsize > SIZE_MAX) || (arburst == BURST_RSVD);
      rslv_d       = rd_look_slv;
    end else if (r_hs) begin
      if (r_last) begin
        rd_state_d = R_IDLE;
      end else begin
        // Prefetch the next beat on the handshake so it is presented on
        // the following cycle without a bubble.
        rcnt_d  = rcnt_q + 8'd1;
        raddr_d = raddr_next;
        rd_load = 1'b1;
      end
    end
  end

`ifdef AXI_BURST_RAM_RANGE_CHECK_EN
  assign rd_look_dec = addr_oob(rd_look_addr);
`else
  assign rd_look_dec = 1'b0;
`endif

  assign rd_look_resp = rd_look_slv ? SLVERR : (rd_look_dec ? DECERR : OKAY);
  assign rd_look_idx  = word_idx(rd_look_addr);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      rid_q      <= '0;
      rlen_q     <= '0;
      rsize_q    <= '0;
      rburst_q   <= BURST_FIXED;
      rslv_q     <= 1'b0;
      rcnt_q     <= '0;
      raddr_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rid_q      <= rid_d;
      rlen_q     <= rlen_d;
      rsize_q    <= rsize_d;
      rburst_q   <= rburst_d;
      rslv_q     <= rslv_d;
      rcnt_q     <= rcnt_d;
      raddr_q    <= raddr_d;
      // A write to the same word on this edge lands after this read sample,
      // so a same-cycle collision returns the old contents.
      if (rd_load) begin
        rdata_q <= rd_look_dec ? '0 : mem[rd_look_idx];
        rresp_q <= rd_look_resp;
      end
    end
  end

  assign arready = (rd_state_q == R_IDLE);
  assign rvalid  = (rd_state_q == R_BURST);
  assign rlast   = (rd_state_q == R_BURST) && r_last;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // --------------------------------------------------------------- write --
  wr_state_t         wr_state_q, wr_state_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [7:0]        wlen_q, wlen_d;
  logic [2:0]        wsize_q, wsize_d;
  logic [1:0]        wburst_q, wburst_d;
  logic              wsz_err_q, wsz_err_d;
  logic              wslv_q, wslv_d;
  logic              wdec_q, wdec_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [1:0]        bresp_q, bresp_d;

  logic              aw_hs, w_hs, w_cnt_last, w_beat_dec, mem_we;
  logic [ADDR_W-1:0] waddr_next;
  logic [IDX_W-1:0]  widx;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr_gen (
    .addr_i      (waddr_q),
    .size_i      (wsize_q),
    .len_i       (wlen_q),
    .burst_i     (wburst_q),
    .next_addr_o (waddr_next)
  );

`ifdef AXI_BURST_RAM_RANGE_CHECK_EN
  assign w_beat_dec = addr_oob(waddr_q);
`else
  assign w_beat_dec = 1'b0;
`endif

  assign aw_hs      = awvalid && (wr_state_q == W_IDLE);
  assign w_hs       = wvalid && (wr_state_q == W_DATA);
  assign w_cnt_last = (wcnt_q == wlen_q);
  assign mem_we     = w_hs && !wsz_err_q && !w_beat_dec;
  assign widx       = word_idx(waddr_q);

  always_comb begin
    wr_state_d = wr_state_q;
    bid_d      = bid_q;
    wlen_d     = wlen_q;
    wsize_d    = wsize_q;
    wburst_d   = wburst_q;
    wsz_err_d  = wsz_err_q;
    wslv_d     = wslv_q;
    wdec_d     = wdec_q;
    wcnt_d     = wcnt_q;
    waddr_d    = waddr_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          wr_state_d = W_DATA;
          bid_d      = awid;
          wlen_d     = awlen;
          wsize_d    = awsize;
          wburst_d   = awburst;
          wsz_err_d  = (awsize > SIZE_MAX);
          wslv_d     = (awsize > SIZE_MAX) || (awburst == BURST_RSVD);
          wdec_d     = 1'b0;
          wcnt_d     = 8'd0;
          waddr_d    = awaddr;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          if (w_cnt_last || wlast) begin
            // Either the count or an early wlast closes the burst; any
            // disagreement between them is reported, never stalled on.
            // Protocol errors outrank a decode error.
            wr_state_d = W_RESP;
            if (wslv_q || (wlast != w_cnt_last)) begin
              bresp_d = SLVERR;
            end else if (wdec_q || w_beat_dec) begin
              bresp_d = DECERR;
            end else begin
              bresp_d = OKAY;
            end
          end else begin
            wcnt_d  = wcnt_q + 8'd1;
            waddr_d = waddr_next;
            wdec_d  = wdec_q || w_beat_dec;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= W_IDLE;
      bid_q      <= '0;
      wlen_q     <= '0;
      wsize_q    <= '0;
      wburst_q   <= BURST_FIXED;
      wsz_err_q  <= 1'b0;
      wslv_q     <= 1'b0;
      wdec_q     <= 1'b0;
      wcnt_q     <= '0;
      waddr_q    <= '0;
      bresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      bid_q      <= bid_d;
      wlen_q     <= wlen_d;
      wsize_q    <= wsize_d;
      wburst_q   <= wburst_d;
      wsz_err_q  <= wsz_err_d;
      wslv_q     <= wslv_d;
      wdec_q     <= wdec_d;
      wcnt_q     <= wcnt_d;
      waddr_q    <= waddr_d;
      bresp_q    <= bresp_d;
    end
  end

  // Array contents are deliberately not reset; beats already written before
  // a reset remain in place.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign awready = (wr_state_q == W_IDLE);
  assign wready  = (wr_state_q == W_DATA);
  assign bvalid  = (wr_state_q == W_RESP);
  assign bid     = bid_q;
  assign bresp   = bresp_q;

  logic unused_sigs;
  assign unused_sigs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

endmodule
